// File: rtl/mem_access_seq.sv
// Load/store sequencer: byte/half/word access to a shared word memory; sub-word stores use read-modify-write.
// Latency: loads READ_LAT+2 cycles to done, SW 2, SB/SH READ_LAT+3, illegal or misaligned requests 1.
// Backpressure: none; req is sampled only in IDLE and ignored (not queued) while busy.
module mem_access_seq #(
    parameter int READ_LAT = 2
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        req,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_dout,
    input  logic [31:0] mem_din
);

    localparam logic [2:0] OP_LW = 3'b000;
    localparam logic [2:0] OP_LH = 3'b001;
    localparam logic [2:0] OP_LB = 3'b010;
    localparam logic [2:0] OP_SW = 3'b100;
    localparam logic [2:0] OP_SH = 3'b101;
    localparam logic [2:0] OP_SB = 3'b110;

    localparam logic [1:0] LAT = 2'(READ_LAT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [1:0]  cnt_q;

    logic [2:0]  op_q;
    logic [1:0]  addr_lo_q;
    logic [15:0] wdata_lo_q;

    logic        busy_d;
    logic        done_d;
    logic        err_d;
    logic        mem_wr_d;
    logic [31:0] rdata_d;
    logic [31:0] mem_addr_d;
    logic [31:0] mem_dout_d;

    logic        legal_in;
    logic        misaligned_in;
    logic        accept;

    // Selects the addressed lane of a little-endian word and sign-extends it.
    function automatic logic [31:0] load_extend(input logic [2:0]  o,
                                                input logic [1:0]  a,
                                                input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (o)
            OP_LH:   return {{16{h[15]}}, h};
            OP_LB:   return {{24{b[7]}}, b};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] merge_store(input logic [2:0]  o,
                                                input logic [1:0]  a,
                                                input logic [31:0] w,
                                                input logic [15:0] d);
        logic [31:0] r;
        r = w;
        if (o == OP_SB) begin
            r[{a, 3'b000} +: 8] = d[7:0];
        end else begin
            r[{a[1], 4'b0000} +: 16] = d;
        end
        return r;
    endfunction

    always_comb begin
        legal_in      = (op == OP_LW) || (op == OP_LH) || (op == OP_LB) ||
                        (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
        misaligned_in = (((op == OP_LW) || (op == OP_SW)) && (addr[1:0] != 2'b00)) ||
                        (((op == OP_LH) || (op == OP_SH)) && addr[0]);
        accept        = (state_q == S_IDLE) && req;
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (!legal_in || misaligned_in) begin
                        state_d = S_ERR;
                    end else if (op == OP_SW) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                if (cnt_q == LAT) begin
                    state_d = op_q[2] ? S_WR : S_DONE;
                end
            end
            S_WR:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are computed from the upcoming state so they register into the matching cycle.
    always_comb begin
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE) || (state_d == S_ERR);
        err_d      = (state_d == S_ERR);
        mem_wr_d   = (state_d == S_WR);
        rdata_d    = rdata;
        mem_addr_d = mem_addr;
        mem_dout_d = mem_dout;

        if (accept && (state_d != S_ERR)) begin
            mem_addr_d = {addr[31:2], 2'b00};
        end
        if (state_q == S_RD && state_d == S_DONE) begin
            rdata_d = load_extend(op_q, addr_lo_q, mem_din);
        end
        if (state_d == S_WR) begin
            mem_dout_d = (state_q == S_IDLE) ? wdata
                                             : merge_store(op_q, addr_lo_q, mem_din, wdata_lo_q);
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            mem_wr   <= 1'b0;
            rdata    <= '0;
            mem_addr <= '0;
            mem_dout <= '0;
        end else begin
            busy     <= busy_d;
            done     <= done_d;
            err      <= err_d;
            mem_wr   <= mem_wr_d;
            rdata    <= rdata_d;
            mem_addr <= mem_addr_d;
            mem_dout <= mem_dout_d;
        end
    end

    // Request context is frozen at acceptance; later input changes have no effect.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            op_q       <= '0;
            addr_lo_q  <= '0;
            wdata_lo_q <= '0;
            cnt_q      <= '0;
        end else begin
            if (accept) begin
                op_q       <= op;
                addr_lo_q  <= addr[1:0];
                wdata_lo_q <= wdata[15:0];
            end
            if (state_q == S_RD) begin
                cnt_q <= cnt_q + 2'd1;
            end else begin
                cnt_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_seq.sv
// Bench for mem_access_seq: directed vectors plus randomized transactions against a
// transaction-level model (expected cycle counts, lane arithmetic, shadow memory).
module tb_mem_access_seq;

    localparam int RL = 2;

    logic        clk;
    logic        Reset;
    logic        req;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [31:0] mem_dout;
    logic [31:0] mem_din;

    int checks = 0;
    int failures = 0;

    mem_access_seq #(.READ_LAT(RL)) dut (
        .clk(clk), .Reset(Reset), .req(req), .op(op), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .err(err), .rdata(rdata), .mem_addr(mem_addr),
        .mem_wr(mem_wr), .mem_dout(mem_dout), .mem_din(mem_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory with RL-cycle read latency, plus a preload port for the bench.
    bit [31:0] mem [256];
    bit [31:0] pipe [3];
    logic      pl_en = 1'b0;
    logic [7:0]  pl_idx = '0;
    logic [31:0] pl_val = '0;
    always @(posedge clk) begin
        pipe[0] <= mem[mem_addr[9:2]];
        pipe[1] <= pipe[0];
        pipe[2] <= pipe[1];
        if (mem_wr) mem[mem_addr[9:2]] <= mem_dout;
        if (pl_en) mem[pl_idx] <= pl_val;
    end
    assign mem_din = pipe[RL-1];

    bit [31:0]   ref_mem [256];
    logic [31:0] ref_rdata = '0;

    int          obs_ndone, obs_done_first, obs_done_last, obs_nerr, obs_err_first;
    int          obs_nwr, obs_wr_first;
    logic [31:0] obs_wr_addr, obs_wr_data;
    logic [31:0] obs_rdata [32];
    logic [31:0] obs_maddr [32];
    logic        obs_busy [32];

    function automatic logic [31:0] ref_load(input logic [2:0] o, input logic [1:0] a,
                                             input logic [31:0] w);
        logic [31:0] v;
        case (o)
            3'd1: begin
                v = (w >> (16 * a[1])) & 32'hFFFF;
                if (v >= 32'h8000) v = v | 32'hFFFF0000;
            end
            3'd2: begin
                v = (w >> (8 * a)) & 32'hFF;
                if (v >= 32'h80) v = v | 32'hFFFFFF00;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [2:0] o, input logic [1:0] a,
                                              input logic [31:0] w, input logic [31:0] d);
        int          sh;
        logic [31:0] mask;
        if (o == 3'd4) return d;
        sh   = (o == 3'd5) ? 16 * a[1] : 8 * a;
        mask = (o == 3'd5) ? 32'hFFFF : 32'hFF;
        return (w & ~(mask << sh)) | ((d & mask) << sh);
    endfunction

    task automatic preload(input int idx, input logic [31:0] v);
        pl_en  = 1'b1;
        pl_idx = idx[7:0];
        pl_val = v;
        @(posedge clk); #1;
        pl_en  = 1'b0;
        ref_mem[idx] = v;
    endtask

    // Issues one request (C0) and records per-cycle outputs for cycles 1..ncyc.
    task automatic do_txn(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                          input int hold, input int ncyc, input bit scramble);
        obs_ndone = 0; obs_done_first = -1; obs_done_last = -1;
        obs_nerr = 0; obs_err_first = -1; obs_nwr = 0; obs_wr_first = -1;
        obs_wr_addr = '0; obs_wr_data = '0;
        @(posedge clk); #1;
        req = 1'b1; op = o; addr = a; wdata = d;
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clk); #1;
            if (k >= hold) req = 1'b0;
            if (scramble) begin
                op = 3'($urandom); addr = $urandom; wdata = $urandom;
            end
            obs_rdata[k] = rdata;
            obs_maddr[k] = mem_addr;
            obs_busy[k]  = busy;
            if (done === 1'b1) begin
                obs_ndone++;
                if (obs_done_first < 0) obs_done_first = k;
                obs_done_last = k;
            end
            if (err === 1'b1) begin
                obs_nerr++;
                if (obs_err_first < 0) obs_err_first = k;
            end
            if (mem_wr === 1'b1) begin
                obs_nwr++;
                if (obs_wr_first < 0) begin
                    obs_wr_first = k; obs_wr_addr = mem_addr; obs_wr_data = mem_dout;
                end
            end
        end
        req = 1'b0;
    endtask

    task automatic test_reset;
        Reset = 1'b1; req = 1'b0; op = '0; addr = '0; wdata = '0;
        #1;
        checks++; if ({busy, done, err, mem_wr} !== 4'b0000) begin failures++;
            $display("FAIL reset_flags got=%b want=0000", {busy, done, err, mem_wr}); end
        checks++; if (rdata !== 32'h0) begin failures++;
            $display("FAIL reset_rdata got=%h want=0", rdata); end
        checks++; if (mem_addr !== 32'h0 || mem_dout !== 32'h0) begin failures++;
            $display("FAIL reset_mem got addr=%h dout=%h want 0", mem_addr, mem_dout); end
        repeat (2) @(posedge clk);
        #1 Reset = 1'b0;
        ref_rdata = '0;
    endtask

    task automatic test_loads;
        preload(4, 32'h87654321);
        do_txn(3'd0, 32'h10, 32'h0, 1, RL + 5, 1'b1);
        checks++; if (obs_maddr[1] !== 32'h10) begin failures++;
            $display("FAIL lw_maddr_c1 got=%h want=00000010", obs_maddr[1]); end
        checks++; if (obs_ndone != 1 || obs_done_first != RL + 2) begin failures++;
            $display("FAIL lw_done got n=%0d cyc=%0d want n=1 cyc=%0d", obs_ndone, obs_done_first, RL + 2); end
        checks++; if (obs_rdata[RL+2] !== 32'h87654321) begin failures++;
            $display("FAIL lw_rdata got=%h want=87654321", obs_rdata[RL+2]); end
        checks++; if (obs_nwr != 0 || obs_nerr != 0) begin failures++;
            $display("FAIL lw_no_wr got wr=%0d err=%0d want 0 0", obs_nwr, obs_nerr); end

        preload(4, 32'h80FF1234);
        do_txn(3'd2, 32'h13, 32'h0, 1, RL + 5, 1'b0);
        checks++; if (obs_rdata[RL+2] !== 32'hFFFFFF80) begin failures++;
            $display("FAIL lb_13 got=%h want=ffffff80", obs_rdata[RL+2]); end
        checks++; if (obs_rdata[1] !== 32'h87654321) begin failures++;
            $display("FAIL rdata_hold got=%h want=87654321", obs_rdata[1]); end
        do_txn(3'd1, 32'h12, 32'h0, 1, RL + 5, 1'b0);
        checks++; if (obs_rdata[RL+2] !== 32'hFFFF80FF) begin failures++;
            $display("FAIL lh_12 got=%h want=ffff80ff", obs_rdata[RL+2]); end
        do_txn(3'd2, 32'h10, 32'h0, 1, RL + 5, 1'b0);
        checks++; if (obs_rdata[RL+2] !== 32'h00000034) begin failures++;
            $display("FAIL lb_10 got=%h want=00000034", obs_rdata[RL+2]); end
        ref_rdata = 32'h00000034;
    endtask

    task automatic test_stores;
        preload(8, 32'h11223344);
        do_txn(3'd6, 32'h21, 32'h000000AB, 1, RL + 5, 1'b1);
        checks++; if (obs_nwr != 1 || obs_wr_first != RL + 2) begin failures++;
            $display("FAIL sb_wr_cycle got n=%0d cyc=%0d want n=1 cyc=%0d", obs_nwr, obs_wr_first, RL + 2); end
        checks++; if (obs_wr_addr !== 32'h20 || obs_wr_data !== 32'h1122AB44) begin failures++;
            $display("FAIL sb_wr_data got %h@%h want 1122ab44@00000020", obs_wr_data, obs_wr_addr); end
        checks++; if (obs_done_first != RL + 3 || obs_ndone != 1) begin failures++;
            $display("FAIL sb_done got cyc=%0d n=%0d want cyc=%0d n=1", obs_done_first, obs_ndone, RL + 3); end
        preload(8, 32'h11223344);
        do_txn(3'd5, 32'h22, 32'h0000BEEF, 1, RL + 5, 1'b0);
        checks++; if (obs_wr_data !== 32'hBEEF3344 || obs_nwr != 1) begin failures++;
            $display("FAIL sh_wr_data got %h n=%0d want beef3344 n=1", obs_wr_data, obs_nwr); end
        ref_mem[8] = 32'hBEEF3344;
        checks++; if (obs_rdata[RL+3] !== ref_rdata) begin failures++;
            $display("FAIL store_rdata_hold got=%h want=%h", obs_rdata[RL+3], ref_rdata); end
    endtask

    task automatic test_errors;
        logic [2:0]  eo [3];
        logic [31:0] ea [3];
        eo[0] = 3'd4; ea[0] = 32'h22;
        eo[1] = 3'd3; ea[1] = 32'h10;
        eo[2] = 3'd1; ea[2] = 32'h13;
        for (int i = 0; i < 3; i++) begin
            do_txn(eo[i], ea[i], 32'hDEADBEEF, 1, 5, 1'b0);
            checks++; if (obs_ndone != 1 || obs_done_first != 1 || obs_nerr != 1 || obs_err_first != 1) begin
                failures++;
                $display("FAIL err_pulse[%0d] got done n=%0d c=%0d err n=%0d c=%0d want 1 1 1 1",
                         i, obs_ndone, obs_done_first, obs_nerr, obs_err_first);
            end
            checks++; if (obs_nwr != 0 || obs_rdata[2] !== ref_rdata || obs_busy[2] !== 1'b0) begin
                failures++;
                $display("FAIL err_side[%0d] got wr=%0d rdata=%h busy=%b want 0 %h 0",
                         i, obs_nwr, obs_rdata[2], obs_busy[2], ref_rdata);
            end
        end
    endtask

    task automatic test_reset_mid;
        int bad;
        @(posedge clk); #1;
        req = 1'b1; op = 3'd0; addr = 32'h10;
        @(posedge clk); #1 req = 1'b0;
        @(posedge clk); #1 Reset = 1'b1;
        #1;
        checks++; if ({busy, done, err, mem_wr} !== 4'b0000 || rdata !== 32'h0 ||
                      mem_addr !== 32'h0 || mem_dout !== 32'h0) begin
            failures++;
            $display("FAIL midreset_outputs got flags=%b rdata=%h addr=%h dout=%h want all 0",
                     {busy, done, err, mem_wr}, rdata, mem_addr, mem_dout);
        end
        @(posedge clk); #1 Reset = 1'b0;
        ref_rdata = '0;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || mem_wr !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin failures++;
            $display("FAIL midreset_quiet got bad_cycles=%0d want 0", bad); end
        do_txn(3'd4, 32'h40, 32'hCAFEF00D, 1, 5, 1'b0);
        checks++; if (obs_nwr != 1 || obs_wr_first != 1 || obs_wr_addr !== 32'h40 ||
                      obs_wr_data !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL sw_after_reset got n=%0d c=%0d %h@%h want 1 1 cafef00d@00000040",
                     obs_nwr, obs_wr_first, obs_wr_data, obs_wr_addr);
        end
        checks++; if (obs_done_first != 2 || obs_ndone != 1) begin failures++;
            $display("FAIL sw_done got cyc=%0d n=%0d want 2 1", obs_done_first, obs_ndone); end
        ref_mem[16] = 32'hCAFEF00D;
    endtask

    task automatic test_back_to_back;
        preload(4, 32'h87654321);
        do_txn(3'd0, 32'h10, 32'h0, 10, 2 * RL + 8, 1'b0);
        checks++; if (obs_ndone != 2 || obs_done_first != RL + 2 || obs_done_last != 2 * RL + 5) begin
            failures++;
            $display("FAIL b2b_done got n=%0d first=%0d last=%0d want 2 %0d %0d",
                     obs_ndone, obs_done_first, obs_done_last, RL + 2, 2 * RL + 5);
        end
        checks++; if (obs_busy[RL+3] !== 1'b0 || obs_busy[RL+4] !== 1'b1 || obs_nwr != 0) begin
            failures++;
            $display("FAIL b2b_busy got idle=%b next=%b wr=%0d want 0 1 0",
                     obs_busy[RL+3], obs_busy[RL+4], obs_nwr);
        end
        ref_rdata = 32'h87654321;
    endtask

    task automatic test_random;
        logic [2:0]  o;
        logic [31:0] a, d, w, e_rd, e_wd, ma;
        bit          legal, mis, e_err, is_ld;
        int          e_done, e_wrc, bad_rd, bad_busy;
        for (int i = 0; i < 16; i++) preload(i, $urandom);
        for (int n = 0; n < 60; n++) begin
            o = 3'($urandom_range(0, 7));
            a = ($urandom & 32'hFFFFFC00) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            d = $urandom;
            w = ref_mem[a[9:2]];
            ma = {a[31:2], 2'b00};
            legal = (o != 3'd3) && (o != 3'd7);
            mis = ((o == 3'd0 || o == 3'd4) && a[1:0] != 2'b00) || ((o == 3'd1 || o == 3'd5) && a[0]);
            e_err = !legal || mis;
            is_ld = !e_err && (o <= 3'd2);
            e_rd = ref_rdata; e_wd = '0; e_wrc = 0;
            if (e_err) e_done = 1;
            else if (is_ld) begin e_done = RL + 2; e_rd = ref_load(o, a[1:0], w); end
            else if (o == 3'd4) begin e_done = 2; e_wrc = 1; e_wd = d; end
            else begin e_done = RL + 3; e_wrc = RL + 2; e_wd = ref_store(o, a[1:0], w, d); end

            do_txn(o, a, d, $urandom_range(1, 2), RL + 5, 1'($urandom));

            checks++; if (obs_ndone != 1 || obs_done_first != e_done) begin failures++;
                $display("FAIL rnd_done[%0d] op=%0d a=%h got n=%0d c=%0d want 1 %0d",
                         n, o, a, obs_ndone, obs_done_first, e_done); end
            checks++; if (obs_nerr != (e_err ? 1 : 0) || (e_err && obs_err_first != 1)) begin failures++;
                $display("FAIL rnd_err[%0d] op=%0d a=%h got n=%0d want %0d", n, o, a, obs_nerr, e_err); end
            checks++; if (obs_nwr != (e_wrc != 0 ? 1 : 0) || obs_wr_first != (e_wrc != 0 ? e_wrc : -1)) begin
                failures++;
                $display("FAIL rnd_wr_cnt[%0d] op=%0d got n=%0d c=%0d want c=%0d", n, o, obs_nwr, obs_wr_first, e_wrc);
            end
            if (e_wrc != 0) begin
                checks++; if (obs_wr_addr !== ma || obs_wr_data !== e_wd) begin failures++;
                    $display("FAIL rnd_wr_data[%0d] op=%0d got %h@%h want %h@%h", n, o, obs_wr_data, obs_wr_addr, e_wd, ma); end
            end
            if (!e_err) begin
                checks++; if (obs_maddr[1] !== ma) begin failures++;
                    $display("FAIL rnd_maddr[%0d] got=%h want=%h", n, obs_maddr[1], ma); end
            end
            bad_rd = 0; bad_busy = 0;
            for (int k = 1; k <= RL + 5; k++) begin
                if (obs_rdata[k] !== ((is_ld && k >= e_done) ? e_rd : ref_rdata)) bad_rd++;
                if (obs_busy[k] !== (k <= e_done)) bad_busy++;
            end
            checks++; if (bad_rd != 0 || bad_busy != 0) begin failures++;
                $display("FAIL rnd_seq[%0d] op=%0d got bad_rdata=%0d bad_busy=%0d want 0 0 (rdata want %h)",
                         n, o, bad_rd, bad_busy, e_rd); end
            ref_rdata = e_rd;
            if (e_wrc != 0) ref_mem[a[9:2]] = e_wd;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        test_reset;
        test_loads;
        test_stores;
        test_errors;
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
